mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 one-bit multiplexer among four requesters. It owns the multiplexer select lines and grants one requester at a time. Each grant is held while the owner keeps requesting, bounded by a fairness limit when others are waiting. It sits directly in front of the multiplexer and presents the selected bit with a valid qualifier to downstream logic.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one owner while another requester waits; legal range is 1..16.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per requester; bit k is requester k.
- `d`  in  4  data bit per requester; d[k] maps to multiplexer input k+1 (i1..i4).
- `grant`  out  4  one-hot grant, registered; all zero when idle.
- `sel`  out  2  multiplexer select, registered; sel[0] drives a1 (LSB), sel[1] drives a2.
- `valid`  out  1  high while a grant is active, registered.
- `out`  out  1  selected data bit gated by valid; out = valid & d[sel].

## Operation
- **State**
  - FSM states are IDLE and GRANT.
  - Rotating priority pointer `ptr` (2 bits) holds the highest-priority index.
  - Hold counter `cnt` is $clog2(MAX_HOLD) bits, minimum 1 bit.
  - Owner index is `own` (equal to sel).
- **Arbitration function pick(ptr, req)**
  - Returns the first index j with req[j]=1.
  - Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- **IDLE**
  - If any req bit is set: own ← pick(ptr, req), grant ← onehot(own), valid ← 1, cnt ← 0, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- **GRANT with owner k**
  - Release condition: req[k]=0, OR (cnt = MAX_HOLD-1 AND some req[j]=1 with j≠k).
  - No release: cnt ← min(cnt+1, MAX_HOLD-1), saturating. Grant, sel and valid are unchanged.
  - On release: ptr ← k+1 mod 4.
    - If any req[j]=1 with j≠k: own ← pick(k+1, req), cnt ← 0, stay in GRANT. The handover has no idle bubble.
    - Otherwise go to IDLE with grant=0 and valid=0.
  - The release condition excludes k, so a forced release always moves ownership to another requester.
- **Single requester**
  - A sole requester keeps the grant indefinitely.
  - cnt saturates; it never forces a release.
- **MAX_HOLD = 1**
  - The owner releases after every cycle whenever another requester is waiting.
  - This gives strict per-cycle rotation.
- **Datapath**
  - `out` is combinational from the registered sel and the live d.
  - It comes through the instantiated multiplexer, ANDed with valid.

## Timing
- **Reset (reset_n=0, asynchronous)**
  - state=IDLE, grant=4'b0000, sel=2'b00, valid=0, ptr=0, cnt=0.
  - out=0.
  - Reset asserted mid-grant drops grant and valid immediately, without waiting for a clock edge.
- **Latency**
  - req is sampled on the rising edge.
  - grant, sel and valid update on that same edge and are visible one cycle after req rises.
- **Handover**
  - When the owner's req falls at edge n, the next grant appears at edge n.
  - grant changes directly from one-hot to one-hot and is never all zero between them.
- **Sticky sel**
  - sel holds its last value while IDLE.
  - out is forced to 0 by valid.
- **Other edge cases**
  - A requester that deasserts req while not owner is simply skipped.
  - A requester that deasserts and reasserts req within one cycle is not detected; only edge samples matter.
  - d changes propagate to out combinationally within the same cycle.

## Structure
- **Shared package/header `mux_arb_defs.vh`**
  - State encodings IDLE=1'b0 and GRANT=1'b1.
  - NUM_REQ=4.
  - SEL_W=2.
- **Sub-module**
  - Instantiate the existing behavioral 4:1 multiplexer with ports (out, a1=sel[0], a2=sel[1], i1..i4=d[0..3]).
  - The AND with valid is done in this block.
- `pick` is a combinational function inside the block; it is not a separate module.

## Test plan
- **Reset:** assert reset_n=0 mid-grant (owner 2) → grant=0000, valid=0 and out=0 immediately, with no clock edge. After release, req=0001 → grant=0001, sel=00 next edge.
- **Round-robin fairness:** MAX_HOLD=4, req=1111 held constant → grant sequence 0001 for 4 cycles, then 0010, 0100, 1000, 0001, each for 4 cycles, with no idle cycle between.
- **Voluntary release:** owner 1 (grant=0010), req 0010→1001 at edge n → at edge n grant=0100? No: pick from ptr=2 gives index 3 → grant=1000, sel=11. Next release goes to index 0.
- **Sole requester:** req=0100 for 20 cycles → grant stays 0100 and valid stays 1 throughout. Drop req → IDLE next edge, grant=0000, sel stays 10.
- **Datapath:** grant on requester 3 (sel=11), d=1000 → out=1; d=0111 → out=0 in the same cycle. In IDLE with d=1111 → out=0.
- **MAX_HOLD=1:** req=0011 → grant alternates 0001, 0010, 0001, … every cycle.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin multiplexer arbiter.
package mux_rr_arbiter_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // One-hot decode of a requester index.
   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      onehot = NUM_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data/grant bundle between requesters and the arbiter.
interface mux_rr_arbiter_if;
   import mux_rr_arbiter_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] d;
   logic [NUM_REQ-1:0] grant;
   logic [SEL_W-1:0]   sel;
   logic               valid;
   logic               out;

   modport master (
      output req,
      output d,
      input  grant,
      input  sel,
      input  valid,
      input  out
   );

   modport slave (
      input  req,
      input  d,
      output grant,
      output sel,
      output valid,
      output out
   );

endinterface

// File: rtl/mux_rr_arbiter_mux4.sv
// Behavioral 4:1 one-bit multiplexer; a2:a1 selects i1..i4.
module mux_rr_arbiter_mux4 (
   output logic out,
   input  logic a1,
   input  logic a2,
   input  logic i1,
   input  logic i2,
   input  logic i3,
   input  logic i4
);

   always_comb begin
      out = 1'b0;
      case ({a2, a1})
         2'b00:   out = i1;
         2'b01:   out = i2;
         2'b10:   out = i3;
         default: out = i4;
      endcase
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 mux select; holds a grant while requested,
// bounded by MAX_HOLD consecutive cycles when another requester is waiting.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
) (
   input logic             clk,
   input logic             reset_n,
   mux_rr_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

   // First requesting index searching p, p+1, p+2, p+3 (mod 4).
   function automatic logic [SEL_W-1:0] pick(input logic [SEL_W-1:0]   p,
                                             input logic [NUM_REQ-1:0] r);
      logic [SEL_W-1:0] idx;
      pick = p;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = p + SEL_W'(i);
         if (r[idx]) pick = idx;
      end
   endfunction

   arb_state_e         state_q, state_nxt;
   logic [SEL_W-1:0]   ptr_q, ptr_nxt;
   logic [SEL_W-1:0]   own_q, own_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic [NUM_REQ-1:0] grant_q, grant_nxt;
   logic               valid_q, valid_nxt;
   logic               others;
   logic               release_c;
   logic [SEL_W-1:0]   next_own;
   logic               mux_y;

   assign others = |(bus.req & ~onehot(own_q));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_nxt;
         ptr_q   <= ptr_nxt;
         own_q   <= own_nxt;
         cnt_q   <= cnt_nxt;
         grant_q <= grant_nxt;
         valid_q <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      ptr_nxt   = ptr_q;
      own_nxt   = own_q;
      cnt_nxt   = cnt_q;
      grant_nxt = grant_q;
      valid_nxt = valid_q;
      release_c = 1'b0;
      next_own  = '0;

      case (state_q)
         ST_IDLE: begin
            if (|bus.req) begin
               next_own  = pick(ptr_q, bus.req);
               own_nxt   = next_own;
               grant_nxt = onehot(next_own);
               valid_nxt = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            release_c = !bus.req[own_q] || ((cnt_q == CNT_MAX) && others);
            if (release_c) begin
               ptr_nxt = own_q + SEL_W'(1);
               if (others) begin
                  // Search starts past the owner, so a forced release never re-grants it.
                  next_own  = pick(own_q + SEL_W'(1), bus.req);
                  own_nxt   = next_own;
                  grant_nxt = onehot(next_own);
                  cnt_nxt   = '0;
               end else begin
                  grant_nxt = '0;
                  valid_nxt = 1'b0;
                  state_nxt = ST_IDLE;
               end
            end else if (cnt_q != CNT_MAX) begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   mux_rr_arbiter_mux4 u_mux (
      .out (mux_y),
      .a1  (own_q[0]),
      .a2  (own_q[1]),
      .i1  (bus.d[0]),
      .i2  (bus.d[1]),
      .i3  (bus.d[2]),
      .i4  (bus.d[3])
   );

   assign bus.grant = grant_q;
   assign bus.sel   = own_q;
   assign bus.valid = valid_q;
   assign bus.out   = valid_q & mux_y;

endmodule
